sprite_draw_scheduler: RTL and testbench



---
 rtl/game_pkg.sv | 36 +++
 rtl/rect_scanner.sv | 89 ++++++++
 rtl/sprite_draw_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg
//   Shared definitions for the sprite drawing path: screen geometry, colour
//   width, the scheduler state encoding and the round-robin index search.
package game_pkg;

  // Widths chosen one bit wider than the coordinates so that a sum of
  // top-left corner plus offset can be compared without wrapping.
  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;
  localparam int         COLOUR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ERASE,
    DRAW,
    DONE
  } state_t;

  // First set bit of req searching ptr+1, ptr+2, ... (mod n).
  // Returns ptr when req is all zero; callers only use it when req != 0.
  function automatic int rr_next(input logic [31:0] req, input int ptr, input int n);
    int   idx;
    logic found;
    rr_next = ptr;
    found   = 1'b0;
    for (int i = 1; i <= n; i++) begin
      idx = (ptr + i) % n;
      if (!found && req[idx[4:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// rect_scanner
//   Raster-scans a size x size square starting at (base_x, base_y), one pixel
//   per cycle, x inner and y outer. The pixel position and its on-screen flag
//   are registered, so the first pixel appears the cycle after start.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             load base/size and begin a new scan (size must be > 0)
//   base_x, base_y    top-left corner of the square
//   size              edge length in pixels, 1..7
//   x, y              current pixel (registered)
//   valid             current pixel is being scanned and lies on screen
//   done              current pixel is the last one of the square
module rect_scanner
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] size,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       valid,
  output logic       done
);

  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] sz;
  logic [2:0] dx, dy, ndx, ndy;
  logic       active;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign done = active && (dx == sz - 3'd1) && (dy == sz - 3'd1);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ndx = dx + 3'd1;
    ndy = dy;
    if (dx == sz - 3'd1) begin
      ndx = 3'd0;
      ndy = dy + 3'd1;
    end
    sum_x = {1'b0, bx} + {6'b0, ndx};
    sum_y = {1'b0, by} + {5'b0, ndy};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx     <= '0;
      by     <= '0;
      sz     <= '0;
      dx     <= '0;
      dy     <= '0;
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      valid  <= 1'b0;
    end else if (start) begin
      bx     <= base_x;
      by     <= base_y;
      sz     <= size;
      dx     <= '0;
      dy     <= '0;
      active <= (size != 3'd0);
      x      <= base_x;
      y      <= base_y;
      valid  <= (size != 3'd0) && ({1'b0, base_x} < SCREEN_W) && ({1'b0, base_y} < SCREEN_H);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
        valid  <= 1'b0;
      end else begin
        dx    <= ndx;
        dy    <= ndy;
        x     <= sum_x[7:0];
        y     <= sum_y[6:0];
        // Off-screen pixels keep their cycle but are not plotted.
        valid <= (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
//   Shares the single VGA plot port among NUM_OBJ objects (index 0 = player).
//   Requests are granted round-robin; for the granted object the previously
//   drawn square is erased in BG_COLOUR and the new square drawn in the
//   object colour, one pixel per cycle.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   req        [NUM_OBJ]               redraw request, held until ack
//   obj_x      [8*NUM_OBJ]             top-left x, object i at [8i+7:8i]
//   obj_y      [7*NUM_OBJ]             top-left y
//   obj_size   [3*NUM_OBJ]             square edge 0..7
//   obj_colour [3*NUM_OBJ]             draw colour
//   ack        [NUM_OBJ]               one-hot completion pulse
//   plot, vga_x, vga_y, vga_colour     registered VGA pixel write
//   busy                               scheduler not in IDLE
module sprite_draw_scheduler
  import game_pkg::*;
#(
  parameter int         NUM_OBJ   = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_OBJ-1:0]      req,
  input  logic [8*NUM_OBJ-1:0]    obj_x,
  input  logic [7*NUM_OBJ-1:0]    obj_y,
  input  logic [3*NUM_OBJ-1:0]    obj_size,
  input  logic [3*NUM_OBJ-1:0]    obj_colour,
  output logic [NUM_OBJ-1:0]      ack,
  output logic                    plot,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [COLOUR_W-1:0]     vga_colour,
  output logic                    busy
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   gnt, rr_ptr;
  logic [7:0]         new_x;
  logic [6:0]         new_y;
  logic [2:0]         new_size;
  logic [2:0]         new_colour;
  logic [NUM_OBJ-1:0] prev_valid;
  logic [7:0]         prev_x    [NUM_OBJ];
  logic [6:0]         prev_y    [NUM_OBJ];
  logic [2:0]         prev_size [NUM_OBJ];

  logic [7:0] in_x      [NUM_OBJ];
  logic [6:0] in_y      [NUM_OBJ];
  logic [2:0] in_size   [NUM_OBJ];
  logic [2:0] in_colour [NUM_OBJ];

  logic       erase_needed;
  logic       scan_start, scan_done, scan_valid;
  logic [7:0] scan_bx, scan_x;
  logic [6:0] scan_by, scan_y;
  logic [2:0] scan_size;

  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      in_x[i]      = obj_x[8*i +: 8];
      in_y[i]      = obj_y[7*i +: 7];
      in_size[i]   = obj_size[3*i +: 3];
      in_colour[i] = obj_colour[3*i +: 3];
    end
  end

  assign erase_needed = prev_valid[gnt] && (prev_size[gnt] != 3'd0);

  // The scanner is started on the edge that enters ERASE/DRAW, so the first
  // pixel of a phase is already on the port during that phase's first cycle.
  // In LATCH the new square is taken straight from the inputs because new_*
  // are only being loaded on that same edge.
  always_comb begin
    scan_start = 1'b0;
    scan_bx    = '0;
    scan_by    = '0;
    scan_size  = '0;
    unique case (state)
      LATCH: begin
        if (erase_needed) begin
          scan_start = 1'b1;
          scan_bx    = prev_x[gnt];
          scan_by    = prev_y[gnt];
          scan_size  = prev_size[gnt];
        end else if (in_size[gnt] != 3'd0) begin
          scan_start = 1'b1;
          scan_bx    = in_x[gnt];
          scan_by    = in_y[gnt];
          scan_size  = in_size[gnt];
        end
      end
      ERASE: begin
        if (scan_done && new_size != 3'd0) begin
          scan_start = 1'b1;
          scan_bx    = new_x;
          scan_by    = new_y;
          scan_size  = new_size;
        end
      end
      default: ;
    endcase
  end

  rect_scanner u_scanner (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .base_x (scan_bx),
    .base_y (scan_by),
    .size   (scan_size),
    .x      (scan_x),
    .y      (scan_y),
    .valid  (scan_valid),
    .done   (scan_done)
  );

  assign plot  = scan_valid;
  assign vga_x = scan_x;
  assign vga_y = scan_y;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= IDX_W'(NUM_OBJ - 1);
      ack        <= '0;
      vga_colour <= '0;
      prev_valid <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_size   <= '0;
      new_colour <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= IDX_W'(rr_next(32'(req), int'(rr_ptr), NUM_OBJ));
            state <= LATCH;
          end
        end
        LATCH: begin
          new_x      <= in_x[gnt];
          new_y      <= in_y[gnt];
          new_size   <= in_size[gnt];
          new_colour <= in_colour[gnt];
          if (erase_needed) begin
            vga_colour <= BG_COLOUR;
            state      <= ERASE;
          end else if (in_size[gnt] != 3'd0) begin
            vga_colour <= in_colour[gnt];
            state      <= DRAW;
          end else begin
            ack   <= NUM_OBJ'(1) << gnt;
            state <= DONE;
          end
        end
        ERASE: begin
          if (scan_done) begin
            if (new_size != 3'd0) begin
              vga_colour <= new_colour;
              state      <= DRAW;
            end else begin
              ack   <= NUM_OBJ'(1) << gnt;
              state <= DONE;
            end
          end
        end
        DRAW: begin
          if (scan_done) begin
            ack   <= NUM_OBJ'(1) << gnt;
            state <= DONE;
          end
        end
        DONE: begin
          prev_valid[gnt] <= (new_size != 3'd0);
          rr_ptr          <= gnt;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the per-object geometry is storage, not control: it is qualified by
  // prev_valid, which is reset, so these arrays need no reset of their own.
  always_ff @(posedge clk) begin
    if (state == DONE) begin
      prev_x[gnt]    <= new_x;
      prev_y[gnt]    <= new_y;
      prev_size[gnt] <= new_size;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] obj_x;
  logic [27:0] obj_y;
  logic [11:0] obj_size;
  logic [11:0] obj_colour;
  logic [3:0]  ack;
  logic        plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        busy;

  sprite_draw_scheduler #(.NUM_OBJ(4), .BG_COLOUR(3'b000)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_size   (obj_size),
    .obj_colour (obj_colour),
    .ack        (ack),
    .plot       (plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Trace of one operation, indexed by cycles since the req-sampling cycle.
  logic       tr_plot [64];
  logic [7:0] tr_x    [64];
  logic [6:0] tr_y    [64];
  logic [2:0] tr_c    [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] s, input logic [2:0] c);
    obj_x[8*i +: 8]      = x;
    obj_y[7*i +: 7]      = y;
    obj_size[3*i +: 3]   = s;
    obj_colour[3*i +: 3] = c;
  endtask

  // Called at a negedge with the DUT idle and req already set. The next
  // posedge samples req; lat counts negedges until ack is seen. The acked
  // requester drops its bit, then one more (IDLE) cycle elapses.
  task automatic run_op(input int budget, output int lat, output logic [3:0] ackv);
    lat  = 0;
    ackv = '0;
    while (lat < budget && ackv == 4'd0) begin
      @(negedge clk);
      lat++;
      tr_plot[lat] = plot;
      tr_x[lat]    = vga_x;
      tr_y[lat]    = vga_y;
      tr_c[lat]    = vga_colour;
      ackv         = ack;
    end
    check("ack_within_budget", 32'(ackv != 4'd0), 1);
    req = req & ~ackv;
    @(negedge clk);
  endtask

  task automatic check_pix(input string tag, input int i, input logic [7:0] x,
                           input logic [6:0] y, input logic [2:0] c);
    check({tag, "_plot"}, 32'(tr_plot[i]), 1);
    check({tag, "_x"}, 32'(tr_x[i]), 32'(x));
    check({tag, "_y"}, 32'(tr_y[i]), 32'(y));
    check({tag, "_c"}, 32'(tr_c[i]), 32'(c));
  endtask

  function automatic int count_plots(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (tr_plot[i]) n++;
    return n;
  endfunction

  int         lat;
  logic [3:0] ackv;

  initial begin
    reset      = 1'b1;
    req        = '0;
    obj_x      = '0;
    obj_y      = '0;
    obj_size   = '0;
    obj_colour = '0;
    repeat (2) @(negedge clk);
    check("rst_plot", 32'(plot), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_vga_x", 32'(vga_x), 0);
    check("rst_vga_y", 32'(vga_y), 0);
    check("rst_colour", 32'(vga_colour), 0);
    reset = 1'b0;
    @(negedge clk);

    // First draw of obj0: no erase, 4 pixels, latency 2 + 4.
    set_obj(0, 8'd10, 7'd20, 3'd2, 3'b100);
    req = 4'b0001;
    run_op(40, lat, ackv);
    check("t1_ack", 32'(ackv), 32'b0001);
    check("t1_lat", lat, 6);
    check("t1_latch_noplot", 32'(tr_plot[1]), 0);
    check_pix("t1_p0", 2, 8'd10, 7'd20, 3'b100);
    check_pix("t1_p1", 3, 8'd11, 7'd20, 3'b100);
    check_pix("t1_p2", 4, 8'd10, 7'd21, 3'b100);
    check_pix("t1_p3", 5, 8'd11, 7'd21, 3'b100);
    check("t1_busy_after", 32'(busy), 0);

    // Move obj0 right by one: erase old square then draw new, latency 2+4+4.
    set_obj(0, 8'd11, 7'd20, 3'd2, 3'b100);
    req = 4'b0001;
    run_op(40, lat, ackv);
    check("t2_ack", 32'(ackv), 32'b0001);
    check("t2_lat", lat, 10);
    check_pix("t2_e0", 2, 8'd10, 7'd20, 3'b000);
    check_pix("t2_e3", 5, 8'd11, 7'd21, 3'b000);
    check_pix("t2_d0", 6, 8'd11, 7'd20, 3'b100);
    check_pix("t2_d1", 7, 8'd12, 7'd20, 3'b100);
    check_pix("t2_d3", 9, 8'd12, 7'd21, 3'b100);

    // Clipping: obj1 at the bottom-right corner, only (159,119) is on screen.
    set_obj(1, 8'd159, 7'd119, 3'd3, 3'b011);
    req = 4'b0010;
    run_op(40, lat, ackv);
    check("t3_ack", 32'(ackv), 32'b0010);
    check("t3_lat", lat, 11);
    check_pix("t3_p0", 2, 8'd159, 7'd119, 3'b011);
    check("t3_plot_count", count_plots(2, 10), 1);

    // Reset during the third pixel of a size-3 draw.
    set_obj(3, 8'd30, 7'd40, 3'd3, 3'b010);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    check("t5_pre_plot", 32'(plot), 1);
    check("t5_pre_x", 32'(vga_x), 32);
    reset = 1'b1;
    #1;
    check("t5_rst_plot", 32'(plot), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ack", 32'(ack), 0);
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    // prev_valid was cleared, so the redraw has no erase phase.
    req = 4'b1000;
    run_op(40, lat, ackv);
    check("t5_ack", 32'(ackv), 32'b1000);
    check("t5_lat", lat, 11);
    check_pix("t5_p0", 2, 8'd30, 7'd40, 3'b010);

    // Size 0 on obj2: no pixels, latency 2, prev_valid stays 0.
    set_obj(2, 8'd5, 7'd5, 3'd0, 3'b111);
    req = 4'b0100;
    run_op(40, lat, ackv);
    check("t6_ack", 32'(ackv), 32'b0100);
    check("t6_lat", lat, 2);
    check("t6_plots", count_plots(1, lat), 0);
    req = 4'b0100;
    run_op(40, lat, ackv);
    check("t6_again_lat", lat, 2);

    // Arbitration. rr_ptr is now 2, so 0101 grants 0 then 2.
    set_obj(0, 8'd50, 7'd50, 3'd1, 3'b001);
    set_obj(1, 8'd70, 7'd70, 3'd1, 3'b110);
    set_obj(2, 8'd60, 7'd60, 3'd1, 3'b101);
    req = 4'b0101;
    run_op(40, lat, ackv);
    check("t4_a_gnt", 32'(ackv), 32'b0001);
    check("t4_a_lat", lat, 3);
    run_op(40, lat, ackv);
    check("t4_b_gnt", 32'(ackv), 32'b0100);
    check("t4_b_lat", lat, 3);          // no erase: obj2 size-0 left prev_valid=0
    check_pix("t4_b_p0", 2, 8'd60, 7'd60, 3'b101);
    // rr_ptr=2: 0111 is served 0, 1, 2.
    req = 4'b0111;
    run_op(40, lat, ackv);
    check("t4_c_gnt", 32'(ackv), 32'b0001);
    check("t4_c_lat", lat, 4);
    check_pix("t4_c_e0", 2, 8'd50, 7'd50, 3'b000);
    run_op(40, lat, ackv);
    check("t4_d_gnt", 32'(ackv), 32'b0010);
    check("t4_d_lat", lat, 3);
    run_op(40, lat, ackv);
    check("t4_e_gnt", 32'(ackv), 32'b0100);
    check("t4_e_lat", lat, 4);
    check("t4_req_clear", 32'(req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
